// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_ORR = 4'b0011,
        OP_EOR = 4'b0100,
        OP_LSL = 4'b0101,
        OP_LSR = 4'b0110,
        OP_ASR = 4'b0111,
        OP_CMP = 4'b1011,
        OP_MUL = 4'b1101
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } alu_state_t;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z, input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle datapath: result and NZCV for every non-MUL opcode, plus
// write enables telling the core which of result/flags the op updates.
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             result_we,
    output logic             flags_we
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]    shamt_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   lsl_s;
    logic [WIDTH:0]   lsr_s;
    logic [WIDTH:0]   asr_s;
    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             res_we_s;
    logic             flg_we_s;

    assign shamt_s = b[SW-1:0];
    assign sum_s   = {1'b0, a} + {1'b0, b};
    assign diff_s  = {1'b0, a} - {1'b0, b};
    // Extra bit beside the operand catches the last bit shifted out (stays 0 for amount 0)
    assign lsl_s   = {1'b0, a} << shamt_s;
    assign lsr_s   = {a, 1'b0} >> shamt_s;
    assign asr_s   = $signed({a, 1'b0}) >>> shamt_s;

    // Opcode decode into result, carry/overflow and write enables
    always_comb begin
        res_s    = {WIDTH{1'b0}};
        c_s      = 1'b0;
        v_s      = 1'b0;
        res_we_s = 1'b1;
        flg_we_s = 1'b1;
        case (op)
            OP_ADD: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res_s    = diff_s[WIDTH-1:0];
                c_s      = ~diff_s[WIDTH];
                v_s      = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
                res_we_s = (op == OP_SUB);
            end
            OP_AND: res_s = a & b;
            OP_ORR: res_s = a | b;
            OP_EOR: res_s = a ^ b;
            OP_LSL: begin
                res_s = lsl_s[WIDTH-1:0];
                c_s   = lsl_s[WIDTH];
            end
            OP_LSR: begin
                res_s = lsr_s[WIDTH:1];
                c_s   = lsr_s[0];
            end
            OP_ASR: begin
                res_s = asr_s[WIDTH:1];
                c_s   = asr_s[0];
            end
            default: begin
                res_s    = {WIDTH{1'b0}};
                flg_we_s = 1'b0;
            end
        endcase
    end

    assign result    = res_s;
    assign flags     = pack_nzcv(res_s[WIDTH-1], res_s == {WIDTH{1'b0}}, c_s, v_s);
    assign result_we = res_we_s;
    assign flags_we  = flg_we_s;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked ALU core: registered result, persistent NZCV flags and an
// iterative shift-add multiplier, with valid/ready on both sides.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    alu_state_t         state_r;
    logic [WIDTH-1:0]   result_r;
    logic [3:0]         flags_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      mul_cnt_r;

    alu_op_t            op_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH-1:0]   comb_result_s;
    logic [3:0]         comb_flags_s;
    logic               comb_result_we_s;
    logic               comb_flags_we_s;

    assign op_s       = alu_op_t'(ALU_Op);
    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign mul_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    alu_comb_unit #(.WIDTH(WIDTH)) u_comb (
        .a         (A),
        .b         (B),
        .op        (op_s),
        .result    (comb_result_s),
        .flags     (comb_flags_s),
        .result_we (comb_result_we_s),
        .flags_we  (comb_flags_we_s)
    );

    // FSM, multiplier iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            result_r  <= {WIDTH{1'b0}};
            flags_r   <= 4'b0000;
            acc_r     <= {(2*WIDTH){1'b0}};
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            mul_cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            if (op_s == OP_MUL) begin
                state_r   <= MUL;
                acc_r     <= {(2*WIDTH){1'b0}};
                mcand_r   <= {{WIDTH{1'b0}}, A};
                mplier_r  <= B;
                mul_cnt_r <= {CW{1'b0}};
            end else begin
                state_r <= DONE;
                if (comb_result_we_s) begin
                    result_r <= comb_result_s;
                end
                if (comb_flags_we_s) begin
                    flags_r <= comb_flags_s;
                end
            end
        end else begin
            case (state_r)
                MUL: begin
                    acc_r     <= mul_next_s;
                    mcand_r   <= mcand_r << 1;
                    mplier_r  <= mplier_r >> 1;
                    mul_cnt_r <= mul_cnt_r + CNT_ONE;
                    // The final partial product is folded in on the same edge that publishes the result
                    if (mul_cnt_r == CNT_LAST) begin
                        state_r  <= DONE;
                        result_r <= mul_next_s[WIDTH-1:0];
                        flags_r  <= pack_nzcv(mul_next_s[WIDTH-1],
                                              mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}},
                                              |mul_next_s[2*WIDTH-1:WIDTH],
                                              1'b0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                IDLE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == MUL);
    assign Result    = result_r;
    assign ALUFlags  = flags_r;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at WIDTH=32.
module tb_alu_seq_core;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_Op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;
    logic        busy;

    int total;
    int bad;

    alu_seq_core #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Op    (ALU_Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .ALUFlags  (ALUFlags),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for in_ready, then let it be accepted on the next edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        ALU_Op   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check_val("issue_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        A        = 32'hDEAD_BEEF;
        B        = 32'h1234_5678;
        ALU_Op   = 4'b0000;
    endtask

    task automatic wait_done(output int cyc, output int viol);
        cyc  = 0;
        viol = 0;
        while (!out_valid && cyc < 100) begin
            if (!busy || in_ready) viol++;
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int viol;
        int seen;
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = 32'h0;
        B         = 32'h0;
        ALU_Op    = 4'b0000;

        step();
        step();
        check_val("rst_result", Result, 32'h0);
        check_val("rst_flags", ALUFlags, 4'b0000);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        reset_n = 1'b1;
        step();
        check_val("rst_in_ready", in_ready, 1);

        // ADD overflow
        issue(4'b0000, 32'h7FFF_FFFF, 32'h1);
        check_val("add_valid", out_valid, 1);
        check_val("add_result", Result, 32'h8000_0000);
        check_val("add_flags", ALUFlags, 4'b1001);
        step();
        check_val("add_drained", out_valid, 0);

        // SUB zero then borrow
        issue(4'b0001, 32'd5, 32'd5);
        check_val("sub_zero_result", Result, 32'h0);
        check_val("sub_zero_flags", ALUFlags, 4'b0110);
        issue(4'b0001, 32'd0, 32'd1);
        check_val("sub_borrow_result", Result, 32'hFFFF_FFFF);
        check_val("sub_borrow_flags", ALUFlags, 4'b1000);

        // CMP keeps the previous result
        issue(4'b0000, 32'd2, 32'd3);
        check_val("add5_result", Result, 32'd5);
        check_val("add5_flags", ALUFlags, 4'b0000);
        issue(4'b1011, 32'd1, 32'd1);
        check_val("cmp_result", Result, 32'd5);
        check_val("cmp_flags", ALUFlags, 4'b0110);
        step();

        // MUL overflow and latency
        issue(4'b1101, 32'h0001_0000, 32'h0001_0000);
        wait_done(cyc, viol);
        check_val("mul_latency", cyc, 32);
        check_val("mul_busy_window", viol, 0);
        check_val("mul_ovf_result", Result, 32'h0);
        check_val("mul_ovf_flags", ALUFlags, 4'b0110);
        step();
        issue(4'b1101, 32'd7, 32'd6);
        wait_done(cyc, viol);
        check_val("mul_small_latency", cyc, 32);
        check_val("mul_small_result", Result, 32'd42);
        check_val("mul_small_flags", ALUFlags, 4'b0000);
        step();

        // Backpressure then back-to-back accept
        out_ready = 1'b0;
        issue(4'b0011, 32'hF0, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("bp_result", Result, 32'hFF);
            check_val("bp_in_ready", in_ready, 0);
            check_val("bp_out_valid", out_valid, 1);
        end
        ALU_Op    = 4'b0010;
        A         = 32'hFF;
        B         = 32'h0F;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("b2b_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check_val("b2b_result", Result, 32'h0F);
        check_val("b2b_out_valid", out_valid, 1);
        step();

        // Reset mid-MUL after leaving non-zero flags behind
        issue(4'b0001, 32'd0, 32'd1);
        check_val("pre_rst_flags", ALUFlags, 4'b1000);
        step();
        issue(4'b1101, 32'd3, 32'd5);
        repeat (9) step();
        check_val("mid_mul_busy", busy, 1);
        reset_n = 1'b0;
        step();
        check_val("mulrst_result", Result, 32'h0);
        check_val("mulrst_flags", ALUFlags, 4'b0000);
        check_val("mulrst_out_valid", out_valid, 0);
        check_val("mulrst_busy", busy, 0);
        reset_n = 1'b1;
        step();
        check_val("mulrst_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) seen++;
            step();
        end
        check_val("mulrst_no_result", seen, 0);

        // Shifts and an unassigned opcode
        issue(4'b0101, 32'h8000_0001, 32'd1);
        check_val("lsl_result", Result, 32'h0000_0002);
        check_val("lsl_flags", ALUFlags, 4'b0010);
        issue(4'b0111, 32'h8000_0000, 32'd4);
        check_val("asr_result", Result, 32'hF800_0000);
        check_val("asr_flags", ALUFlags, 4'b1000);
        issue(4'b0110, 32'h0000_0003, 32'd1);
        check_val("lsr_result", Result, 32'h1);
        check_val("lsr_flags", ALUFlags, 4'b0010);
        issue(4'b0101, 32'h0000_00FF, 32'h0000_0020);
        check_val("lsl0_result", Result, 32'hFF);
        check_val("lsl0_flags", ALUFlags, 4'b0000);
        issue(4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F);
        check_val("eor_result", Result, 32'hF0F0_0F0F);
        check_val("eor_flags", ALUFlags, 4'b1000);
        issue(4'b1111, 32'd9, 32'd9);
        check_val("undef_result", Result, 32'h0);
        check_val("undef_flags", ALUFlags, 4'b1000);
        check_val("undef_valid", out_valid, 1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the combinational 32-bit ALU. It registers its results and keeps a persistent NZCV flag register. Single-cycle ops complete with 1-cycle latency; an iterative shift-add MUL completes in WIDTH cycles. It sits between the decode/issue stage and writeback, and uses valid/ready on both sides so it can absorb writeback stalls.

## Interface
- WIDTH, 32, operand/result width; ≥ 4, power of two.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  core can accept an op this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; shift amount = B[$clog2(WIDTH)-1:0].
- ALU_Op  in  4  opcode (see Operation).
- out_valid  out  1  Result/ALUFlags hold a completed op.
- out_ready  in  1  consumer takes the result.
- Result  out  WIDTH  registered result.
- ALUFlags  out  4  persistent flags {N,Z,C,V}.
- busy  out  1  MUL iteration in progress.

## Operation
Opcodes:
- 0000 ADD
- 0001 SUB (A−B)
- 0010 AND
- 0011 ORR
- 0100 EOR
- 0101 LSL
- 0110 LSR
- 0111 ASR
- 1011 CMP (A−B, flags only)
- 1101 MUL (unsigned, low WIDTH bits)
- All other codes: Result=0, flags unchanged, handshake completes normally.

Flag rules (N = Result[WIDTH-1], Z = Result==0 for every flag-updating op):
- ADD: C = carry out; V = signed overflow.
- SUB/CMP: C = NOT borrow (A ≥ B unsigned); V = signed overflow.
- AND/ORR/EOR: C=0, V=0.
- Shifts: C = last bit shifted out (0 if amount 0); V=0.
- MUL: C = OR of upper WIDTH bits of the 2·WIDTH product; V=0.
- CMP: Result register keeps its previous value; flags update.

State machine:
- IDLE → DONE on accept of a non-MUL op.
- IDLE → MUL on accept of MUL; WIDTH iterations, then → DONE.
- DONE → IDLE when out_ready.
- DONE → DONE when out_ready is high and in_valid of a non-MUL op is accepted in the same cycle (back-to-back).
- DONE → MUL when out_ready is high and a MUL is accepted in the same cycle.

Handshake:
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- An op is accepted when in_valid & in_ready.
- out_valid = (state==DONE).
- Result and ALUFlags are stable while out_valid & !out_ready.

Arithmetic:
- All arithmetic is modulo 2^WIDTH.
- ADD/SUB are computed at WIDTH+1 bits for the carry.
- MUL uses a 2·WIDTH accumulator, multiplicand shifted left, and multiplier shifted right one bit per cycle.

## Timing
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, Result=0, ALUFlags=4'b0000, out_valid=0, busy=0.
  - in_ready=1 in the first cycle after reset release.
- Non-MUL op accepted at edge t: out_valid=1 from edge t+1.
- MUL accepted at edge t:
  - busy=1 and in_ready=0 for edges t+1..t+WIDTH−1.
  - out_valid=1 from edge t+WIDTH.
- Reset asserted mid-MUL: the op is abandoned, all outputs return to reset values at that edge, and no result is produced.
- in_valid while in_ready=0: ignored; the producer must hold.
- Inputs are sampled only at the accept edge; later changes to A/B/ALU_Op do not affect an in-flight MUL.

## Structure
- Package alu_pkg:
  - alu_op_t enum (4-bit, codes above).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - State enum alu_state_t {IDLE, MUL, DONE}.
- Sub-module alu_comb_unit (#WIDTH): purely combinational single-cycle datapath producing result and NZCV for all non-MUL ops; instantiated once.
- The core holds the FSM, MUL iterator, and output/flag registers.

## Test plan
All scenarios use WIDTH=32.
- **ADD overflow:** ADD A=0x7FFFFFFF, B=1 → Result=0x80000000, ALUFlags=4'b1001, out_valid 1 cycle after accept.
- **SUB zero and borrow:** SUB 5−5 → Result=0, flags 4'b0110. Then SUB 0−1 → 0xFFFFFFFF, flags 4'b1000.
- **CMP preserves Result:** ADD 2+3 (Result=5), then CMP 1,1 → Result stays 5, flags 4'b0110.
- **MUL timing and overflow:** MUL 0x10000×0x10000 → Result=0, flags 4'b0110, out_valid exactly 32 cycles after accept, in_ready=0 and busy=1 in between. Then MUL 7×6 → 42, flags 4'b0000.
- **Backpressure:**
  - Hold out_ready=0 for 3 cycles after ORR 0xF0|0x0F → Result=0xFF stable, in_ready=0.
  - Raise out_ready together with in_valid (AND 0xFF&0x0F) → second op accepted that cycle, Result=0x0F next cycle.
- **Reset mid-MUL:** drop reset_n 10 cycles into a MUL → next cycle Result=0, ALUFlags=0, out_valid=0, busy=0, in_ready=1 after release. Then shift checks: LSL 0x80000001 by 1 → 0x00000002, flags C=1 (4'b0010).
